alu_md: RTL

Parametrised successor to the pipeline's combinational ALU: same logic/shift/add operation set at configurable width, plus signed add/sub overflow, set-less-than, and an iterative multiply/divide unit with architectural HI/LO registers. Sits in the EX stage; combinational ops return in the same cycle, multiply/divide run for WIDTH+1 cycles behind a start/busy/done handshake that the hazard unit uses to stall.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/muldiv_iter.sv | 149 ++++++++++++++
 rtl/alu_md.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, mult/div FSM states and op classification helper
// Contents: OP_* 5-bit operation codes, md_state_t (IDLE, RUN, FIX), is_muldiv()
package alu_pkg;

    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_NOR  = 5'b00011;
    localparam logic [4:0] OP_LUI  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_SLLV = 5'b01011;
    localparam logic [4:0] OP_SRLV = 5'b01100;
    localparam logic [4:0] OP_SRAV = 5'b01101;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_ADDU = 5'b10001;
    localparam logic [4:0] OP_SUB  = 5'b10010;
    localparam logic [4:0] OP_SUBU = 5'b10011;
    localparam logic [4:0] OP_SLT  = 5'b10100;
    localparam logic [4:0] OP_SLTU = 5'b10101;
    localparam logic [4:0] OP_MULT = 5'b11000;
    localparam logic [4:0] OP_MULTU = 5'b11001;
    localparam logic [4:0] OP_DIV  = 5'b11010;
    localparam logic [4:0] OP_DIVU = 5'b11011;
    localparam logic [4:0] OP_MFHI = 5'b11100;
    localparam logic [4:0] OP_MFLO = 5'b11101;
    localparam logic [4:0] OP_MTHI = 5'b11110;
    localparam logic [4:0] OP_MTLO = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // MULT/MULTU/DIV/DIVU occupy 110xx: bit 1 selects divide, bit 0 selects unsigned
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:2] == 3'b110;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider
// Ports: clk, rst (sync, active-high); start (mult/div issue), is_div, is_signed,
//        flush, a, b (operands); busy, done (pulse), wr strobe with wr_hi/wr_lo data
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr,
    output logic [WIDTH-1:0] wr_hi,
    output logic [WIDTH-1:0] wr_lo
);

    md_state_t state, state_next;

    logic [SHW-1:0]     cnt;
    logic               is_div_q, neg_a_q, neg_b_q, b_zero_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem, quo, dvsr;

    // The iteration runs on magnitudes; signs are re-applied in FIX
    logic             neg_a, neg_b, accept, last_step;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign neg_a     = is_signed & a[WIDTH-1];
    assign neg_b     = is_signed & b[WIDTH-1];
    assign mag_a     = neg_a ? -a : a;
    assign mag_b     = neg_b ? -b : b;
    assign accept    = (state == IDLE) && start && !flush;
    assign last_step = (cnt == SHW'(WIDTH - 1));

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    // The difference is always < divisor, so WIDTH bits of it are exact.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, dvsr};
    assign div_sub   = div_shift[WIDTH-1:0] - dvsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        wr         = 1'b0;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                wr         = !flush;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            done     <= 1'b0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
        end else begin
            done <= wr;
            if (accept) begin
                cnt      <= '0;
                is_div_q <= is_div;
                neg_a_q  <= neg_a;
                neg_b_q  <= neg_b;
                b_zero_q <= (b == '0);
                a_q      <= a;
                prod     <= '0;
                mcand    <= {{WIDTH{1'b0}}, mag_a};
                mplier   <= mag_b;
                rem      <= '0;
                quo      <= mag_a;
                dvsr     <= mag_b;
            end else if (state == RUN) begin
                cnt <= cnt + SHW'(1);
                if (is_div_q) begin
                    rem <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], div_ge};
                end else begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
            end
        end
    end

    // Sign fix-up; divide by zero bypasses it and returns all-ones / dividend
    logic [2*WIDTH-1:0] prod_fix;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;

    always_comb begin
        wr_hi = prod_fix[2*WIDTH-1:WIDTH];
        wr_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                wr_hi = a_q;
                wr_lo = '1;
            end else begin
                wr_hi = neg_a_q ? -rem : rem;
                wr_lo = (neg_a_q ^ neg_b_q) ? -quo : quo;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - EX-stage ALU with HI/LO registers and iterative mult/div
// Ports: clk, rst (sync, active-high); a, b, sa, op, start, flush (inputs);
//        y, overflow, zero (combinational); busy, done, hi, lo (registered)
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   sa,
    input  logic [4:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             md_wr;
    logic [WIDTH-1:0] md_hi, md_lo;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start && is_muldiv(op)),
        .is_div    (op[1]),
        .is_signed (!op[0]),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .wr        (md_wr),
        .wr_hi     (md_hi),
        .wr_lo     (md_lo)
    );

    // MTHI/MTLO cannot collide with a mult/div write: the unit is busy in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (md_wr) begin
            hi <= md_hi;
            lo <= md_lo;
        end else if (start && !busy) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end
    end

    logic [WIDTH-1:0] sum, diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y        = '0;
        overflow = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_LUI:  y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL:  y = b << sa;
            OP_SRL:  y = b >> sa;
            OP_SRA:  y = $signed(b) >>> sa;
            OP_SLLV: y = b << a[SHW-1:0];
            OP_SRLV: y = b >> a[SHW-1:0];
            OP_SRAV: y = $signed(b) >>> a[SHW-1:0];
            OP_ADD: begin
                y        = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: y = sum;
            OP_SUB: begin
                y        = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: y = diff;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: y = hi;
            OP_MFLO: y = lo;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule
